scope_trigger_capture: RTL and testbench



---
 rtl/scope_pkg.sv | 16 +
 rtl/scope_capture_ram.sv | 44 ++++
 rtl/scope_trigger_capture.sv | 257 +++++++++++++++++++++++++
 tb/tb_scope_trigger_capture.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types for the scope capture stage: capture FSM states and the
// trigger-slope encoding used by trig_slope.
package scope_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWaitTrig,
    StPost,
    StReadout
  } scope_state_e;

  localparam logic SlopeRising  = 1'b0;
  localparam logic SlopeFalling = 1'b1;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port record buffer, (1 << ADDR_W) x DATA_W, one write port and
// one registered read port.
//   clk_i            clock
//   rst_ni           async active-low reset (clears the read register only)
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read port; rdata_o updates only when re_i is high
//   rdata_o          registered read data (1-cycle latency)
module scope_capture_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds while re_i is low so a stalled consumer sees stable data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_trigger_capture.sv
// Scope sample capture: decimates ADC samples, keeps pre-trigger history in a
// circular buffer, detects a level/slope trigger, completes the record to
// 2**DEPTH_LOG2 samples, then streams it oldest-first over valid/ready.
// Ports:
//   sys_clk, rst_n                    clock, async active-low reset
//   adc_data, adc_valid               sample input
//   arm                               start request (honoured in idle only)
//   trig_level, trig_slope            trigger threshold / 0 rising, 1 falling
//   pretrig_len, decim                pre-trigger length, keep 1 of decim+1
//   rd_data, rd_valid, rd_ready, rd_last  record readout stream
//   busy, triggered, done             status
// Optional macro AUTO_TRIG_EN: forced trigger after AUTO_TIMEOUT accepted
// samples spent waiting for a trigger.
module scope_trigger_capture
  import scope_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned DECIM_W      = 16,
  parameter int unsigned AUTO_TIMEOUT = 2000000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  input  logic                  arm,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  trig_slope,
  input  logic [DEPTH_LOG2-1:0] pretrig_len,
  input  logic [DECIM_W-1:0]    decim,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done
);

  scope_state_e state_q, state_d;

  logic [DECIM_W-1:0]    decim_q, decim_d, decim_cnt_q, decim_cnt_d;
  logic [DATA_W-1:0]     level_q, level_d, prev_q, prev_d;
  logic                  slope_q, slope_d, prev_valid_q, prev_valid_d;
  logic [DEPTH_LOG2-1:0] pretrig_q, pretrig_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d, rd_addr_q, rd_addr_d, hs_cnt_q, hs_cnt_d;
  logic                  triggered_q, triggered_d, rd_valid_q, rd_valid_d, done_q, done_d;

  logic                  capturing, accept, trig_cond, force_trig, pre_full, trig_fire;
  logic                  rd_hs, rd_final, rd_en, ram_we;
  logic [DEPTH_LOG2-1:0] post_init;

  assign capturing = (state_q == StPre) || (state_q == StWaitTrig) || (state_q == StPost);
  assign accept    = capturing && adc_valid && (decim_cnt_q == decim_q);
  assign pre_full  = (cnt_q == pretrig_q - 1'b1);
  // Remaining post-trigger samples: DEPTH - pretrig - 1.
  assign post_init = ~pretrig_q;

  always_comb begin
    trig_cond = 1'b0;
    unique case (slope_q)
      SlopeRising:  trig_cond = (prev_q < level_q) && (adc_data >= level_q);
      SlopeFalling: trig_cond = (prev_q > level_q) && (adc_data <= level_q);
      default:      trig_cond = 1'b0;
    endcase
    trig_cond = trig_cond && prev_valid_q;
  end

`ifdef AUTO_TRIG_EN
  logic [31:0] auto_cnt_q, auto_cnt_d;
  assign force_trig = (auto_cnt_q == AUTO_TIMEOUT - 1);
`else
  logic unused_auto_timeout;
  assign unused_auto_timeout = ^AUTO_TIMEOUT;
  assign force_trig = 1'b0;
`endif

  // A trigger on the sample that completes the pre-trigger count wins over
  // moving to the wait state.
  assign trig_fire = accept &&
                     (((state_q == StWaitTrig) && (trig_cond || force_trig)) ||
                      ((state_q == StPre) && pre_full && trig_cond));

  assign rd_hs    = rd_valid_q && rd_ready;
  assign rd_final = rd_hs && (hs_cnt_q == '1);
  assign rd_en    = (state_q == StReadout) && (!rd_valid_q || (rd_ready && (hs_cnt_q != '1)));

  // FSM: state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arm) state_d = (pretrig_len == '0) ? StWaitTrig : StPre;
      end
      StPre: begin
        if (trig_fire)               state_d = (post_init == '0) ? StReadout : StPost;
        else if (accept && pre_full) state_d = StWaitTrig;
      end
      StWaitTrig: begin
        if (trig_fire) state_d = (post_init == '0) ? StReadout : StPost;
      end
      StPost: begin
        if (accept && (cnt_q == DEPTH_LOG2'(1))) state_d = StReadout;
      end
      StReadout: begin
        if (rd_final) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy    = (state_q != StIdle);
    rd_last = rd_valid_q && (hs_cnt_q == '1);
    ram_we  = accept;
  end

  // Datapath next state
  always_comb begin
    decim_d      = decim_q;
    level_d      = level_q;
    slope_d      = slope_q;
    pretrig_d    = pretrig_q;
    decim_cnt_d  = decim_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    triggered_d  = triggered_q;
    rd_addr_d    = rd_addr_q;
    hs_cnt_d     = hs_cnt_q;
    rd_valid_d   = rd_valid_q;
    done_d       = rd_final;
`ifdef AUTO_TRIG_EN
    auto_cnt_d   = auto_cnt_q;
`endif

    if ((state_q == StIdle) && arm) begin
      decim_d      = decim;
      level_d      = trig_level;
      slope_d      = trig_slope;
      pretrig_d    = pretrig_len;
      decim_cnt_d  = '0;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      prev_valid_d = 1'b0;
      triggered_d  = 1'b0;
`ifdef AUTO_TRIG_EN
      auto_cnt_d   = '0;
`endif
    end

    if (capturing && adc_valid) begin
      decim_cnt_d = (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + 1'b1;
    end

    if (accept) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      prev_d       = adc_data;
      prev_valid_d = 1'b1;
      if (state_q == StPre)  cnt_d = cnt_q + 1'b1;
      if (state_q == StPost) cnt_d = cnt_q - 1'b1;
`ifdef AUTO_TRIG_EN
      if (state_q == StWaitTrig) auto_cnt_d = auto_cnt_q + 1'b1;
`endif
    end

    if (trig_fire) begin
      triggered_d = 1'b1;
      cnt_d       = post_init;
    end

    // After the final write wr_ptr points at the oldest sample of the record.
    if ((state_q != StReadout) && (state_d == StReadout)) begin
      rd_addr_d = wr_ptr_d;
      hs_cnt_d  = '0;
    end

    if (rd_en) begin
      rd_addr_d  = rd_addr_q + 1'b1;
      rd_valid_d = 1'b1;
    end else if (rd_hs) begin
      rd_valid_d = 1'b0;
    end

    if (rd_hs) hs_cnt_d = hs_cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q      <= '0;
      level_q      <= '0;
      slope_q      <= 1'b0;
      pretrig_q    <= '0;
      decim_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      triggered_q  <= 1'b0;
      rd_addr_q    <= '0;
      hs_cnt_q     <= '0;
      rd_valid_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef AUTO_TRIG_EN
      auto_cnt_q   <= '0;
`endif
    end else begin
      decim_q      <= decim_d;
      level_q      <= level_d;
      slope_q      <= slope_d;
      pretrig_q    <= pretrig_d;
      decim_cnt_q  <= decim_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      triggered_q  <= triggered_d;
      rd_addr_q    <= rd_addr_d;
      hs_cnt_q     <= hs_cnt_d;
      rd_valid_q   <= rd_valid_d;
      done_q       <= done_d;
`ifdef AUTO_TRIG_EN
      auto_cnt_q   <= auto_cnt_d;
`endif
    end
  end

  assign rd_valid  = rd_valid_q;
  assign triggered = triggered_q;
  assign done      = done_q;

  scope_capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (sys_clk),
    .rst_ni (rst_n),
    .we_i   (ram_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(adc_data),
    .re_i   (rd_en),
    .raddr_i(rd_addr_q),
    .rdata_o(rd_data)
  );

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench for scope_trigger_capture (default parameters, AUTO_TIMEOUT=100).
module tb_scope_trigger_capture;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       arm;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic [9:0] pretrig_len;
  logic [15:0] decim;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       rd_last;
  logic       busy;
  logic       triggered;
  logic       done;

  scope_trigger_capture #(
    .DATA_W      (8),
    .DEPTH_LOG2  (10),
    .DECIM_W     (16),
    .AUTO_TIMEOUT(100)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .pretrig_len(pretrig_len),
    .decim      (decim),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_last    (rd_last),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int vidx  = 0;
  int mode  = 0;      // 0 ramp up, 1 ramp down, 2 constant 50
  bit toggle = 1'b0;  // insert an invalid cycle before every valid sample
  int arm_at = -1;    // valid-sample index on which arm is pulsed

  logic [7:0] rec [1024];
  int rec_n, last_cnt, last_idx, done_cnt, stall_bad, first_valid, errs;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int v);
    case (mode)
      0:       return 8'(v % 256);
      1:       return 8'(255 - (v % 256));
      default: return 8'd50;
    endcase
  endfunction

  task automatic do_arm(input int d, input int p, input int l, input bit s);
    adc_valid   = 1'b0;
    decim       = 16'(d);
    pretrig_len = 10'(p);
    trig_level  = 8'(l);
    trig_slope  = s;
    arm         = 1'b1;
    tick();
    arm  = 1'b0;
    vidx = 0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        adc_valid = 1'b0;
        arm       = 1'b0;
        tick();
      end
      adc_data  = gen(vidx);
      adc_valid = 1'b1;
      arm       = (vidx == arm_at);
      tick();
      vidx++;
    end
    adc_valid = 1'b0;
    arm       = 1'b0;
  endtask

  // Collects one record; optionally holds rd_ready low for stall_len cycles
  // just before record index stall_at is taken.
  task automatic readout(input int stall_at, input int stall_len);
    int cyc, stalled;
    logic ready;
    logic [7:0] hold;
    rec_n = 0; last_cnt = 0; last_idx = -1; done_cnt = 0;
    stall_bad = 0; first_valid = -1; cyc = 0; stalled = 0; hold = '0;
    while (rec_n < 1024 && cyc < 5000) begin
      if (rd_valid && first_valid < 0) first_valid = cyc;
      if (done) done_cnt++;
      ready = !(rec_n == stall_at && stalled < stall_len);
      if (!ready) begin
        if (stalled == 0) hold = rd_data;
        else if (rd_data !== hold) stall_bad++;
        if (!rd_valid) stall_bad++;
        stalled++;
      end
      rd_ready = ready;
      if (rd_valid && ready) begin
        rec[rec_n] = rd_data;
        if (rd_last) begin
          last_cnt++;
          last_idx = rec_n;
        end
        rec_n++;
      end
      tick();
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; trig_level = '0;
    trig_slope = 1'b0; pretrig_len = '0; decim = '0; rd_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_triggered", triggered, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // 1: rising ramp, pretrig 256; arm pulsed mid-POST must be ignored.
    do_arm(0, 256, 128, 1'b0);
    check("t1_busy_armed", busy, 1);
    mode = 0;
    feed(384);
    check("t1_not_trig_yet", triggered, 0);
    feed(1);
    check("t1_trig", triggered, 1);
    feed(115);
    decim = 16'd2; pretrig_len = 10'd0; arm_at = 500;
    feed(1);
    arm_at = -1;
    check("t5_arm_post_busy", busy, 1);
    check("t5_arm_post_trig", triggered, 1);
    feed(651);
    check("t1_entry_rd_valid", rd_valid, 0);
    check("t1_entry_busy", busy, 1);
    readout(-1, 0);
    check("t1_first_valid_lat", first_valid, 1);
    check("t1_len", rec_n, 1024);
    check("t1_rec256", rec[256], 128);
    errs = 0;
    for (int k = 0; k < 1024; k++) if (rec[k] !== 8'((128 + k) % 256)) errs++;
    check("t1_contig_errs", errs, 0);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_last_idx", last_idx, 1023);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_idle_busy", busy, 0);

    // 2: falling ramp with a 5-cycle stall mid-readout.
    rd_ready = 1'b0;
    do_arm(0, 256, 128, 1'b1);
    mode = 1;
    feed(383);
    check("t2_not_trig_yet", triggered, 0);
    feed(1);
    check("t2_trig", triggered, 1);
    feed(767);
    readout(500, 5);
    check("t2_len", rec_n, 1024);
    check("t2_rec0", rec[0], 128);
    check("t2_rec256", rec[256], 128);
    errs = 0;
    for (int k = 0; k < 1024; k++) if (rec[k] !== 8'(255 - ((127 + k) % 256))) errs++;
    check("t2_contig_errs", errs, 0);
    check("t4_stall_stable", stall_bad, 0);
    check("t2_last_idx", last_idx, 1023);
    check("t2_done_cnt", done_cnt, 1);

    // 3: decim=3, first with constant valid then with valid toggling.
    for (int pass = 0; pass < 2; pass++) begin
      rd_ready = 1'b0;
      toggle = (pass == 1);
      do_arm(3, 0, 128, 1'b0);
      mode = 0;
      feed(131);
      check("t3_not_trig_yet", triggered, 0);
      feed(1);
      check("t3_trig", triggered, 1);
      feed(4092);
      check("t3_entry_rd_valid", rd_valid, 0);
      readout(-1, 0);
      check("t3_first_valid_lat", first_valid, 1);
      check("t3_len", rec_n, 1024);
      check("t3_rec0", rec[0], 131);
      errs = 0;
      for (int k = 0; k < 1024; k++) if (rec[k] !== 8'((131 + 4 * k) % 256)) errs++;
      check("t3_step4_errs", errs, 0);
      check("t3_done_cnt", done_cnt, 1);
    end
    toggle = 1'b0;

    // 5: async reset while waiting for a trigger.
    rd_ready = 1'b0;
    do_arm(0, 0, 200, 1'b0);
    mode = 2;
    feed(20);
    check("t5_wait_busy", busy, 1);
    check("t5_wait_not_trig", triggered, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_rd_data", rd_data, 0);
    check("t5_rst_rd_valid", rd_valid, 0);
    check("t5_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_after_rst_busy", busy, 0);

    // 6: constant input never crosses the level.
    do_arm(0, 0, 128, 1'b0);
    mode = 2;
`ifdef AUTO_TRIG_EN
    feed(99);
    check("t6_not_trig_yet", triggered, 0);
    feed(1);
    check("t6_forced_trig", triggered, 1);
    feed(1023);
    readout(-1, 0);
    check("t6_len", rec_n, 1024);
    errs = 0;
    for (int k = 0; k < 1024; k++) if (rec[k] !== 8'd50) errs++;
    check("t6_const_errs", errs, 0);
    check("t6_done_cnt", done_cnt, 1);
`else
    feed(300);
    check("t6_no_trig", triggered, 0);
    check("t6_still_busy", busy, 1);
    check("t6_no_rd_valid", rd_valid, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
